// File: rtl/uart_transmit.sv
// rtl/uart_transmit.sv - 8N1 UART transmitter with strobe/ack byte input.
// Optional even parity bit when UART_TRANSMIT_PARITY_EN is defined.
module uart_transmit #(
  parameter real BAUD = 9600.0,
  parameter int  FREQ = 12000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stb,
  input  logic [7:0] dat,
  output logic       ack,
  output logic       tx
);

  localparam int DIV = $rtoi(real'(FREQ) / BAUD + 0.5);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

`ifdef UART_TRANSMIT_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          ack_q, ack_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign bit_end = (div_q == CW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      ack_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      ack_q   <= ack_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    if (state_q == IDLE) begin
      div_d = '0;
      if (stb) begin
        state_d = START;
        shift_d = dat;
        par_d   = ^dat;
        bit_d   = '0;
      end
    end else if (!bit_end) begin
      div_d = div_q + 1'b1;
    end else begin
      div_d = '0;
      case (state_q)
        START: state_d = DATA;
        DATA: begin
          if (bit_q == 3'd7) begin
`ifdef UART_TRANSMIT_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
`ifdef UART_TRANSMIT_PARITY_EN
        PARITY: state_d = STOP;
`endif
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // tx is computed from the upcoming state so the line register changes on the bit edge
  always_comb begin
    ack_d = (state_q == IDLE) && stb;
    tx_d  = 1'b1;
    case (state_d)
      IDLE:   tx_d = 1'b1;
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_d[0];
`ifdef UART_TRANSMIT_PARITY_EN
      PARITY: tx_d = par_q;
`endif
      STOP:   tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  assign ack = ack_q;
  assign tx  = tx_q;

endmodule

// File: tb/tb_uart_transmit.sv
// tb/tb_uart_transmit.sv - directed self-checking bench for uart_transmit.
module tb_uart_transmit;

  localparam int DIV = 1250;
`ifdef UART_TRANSMIT_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       stb;
  logic [7:0] dat;
  logic       ack;
  logic       tx;
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_transmit dut (
    .clk(clk),
    .rst(rst),
    .stb(stb),
    .dat(dat),
    .ack(ack),
    .tx (tx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef UART_TRANSMIT_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b0, 1'b1, b, 1'b0};
`endif
  endfunction

  // Serial monitor: find the start bit, then sample every bit near its centre.
  task automatic rx_frame(output logic [10:0] f);
    int n;
    f = '0;
    n = 0;
    while (tx !== 1'b0 && n < 4 * DIV) begin
      @(negedge clk);
      n++;
    end
    check("rx_start_seen", 32'(n < 4 * DIV), 32'd1);
    repeat (DIV / 2) @(negedge clk);
    for (int i = 0; i < NB; i++) begin
      f[i] = tx;
      if (i < NB - 1) repeat (DIV) @(negedge clk);
    end
  endtask

  task automatic offer(input logic [7:0] b, input string tag);
    stb = 1'b1;
    dat = b;
    @(negedge clk);
    check({tag, "_ack_hi"}, 32'(ack), 32'd1);
    stb = 1'b0;
    dat = ~b;
    @(negedge clk);
    check({tag, "_ack_lo"}, 32'(ack), 32'd0);
  endtask

  task automatic settle();
    repeat (DIV / 2 + 2) @(negedge clk);
  endtask

  // Two bytes with stb held: checks ack spacing and an unbroken stop bit.
  task automatic b2b(input logic [7:0] b1, input logic [7:0] b2, input string tag,
                     output logic [10:0] f1, output logic [10:0] f2);
    int a0, a1, n;
    logic stop_ok;
    stb = 1'b1;
    dat = b1;
    @(negedge clk);
    check({tag, "_ack1"}, 32'(ack), 32'd1);
    a0 = cyc;
    dat = b2;
    rx_frame(f1);
    stop_ok = 1'b1;
    n = 0;
    while (ack !== 1'b1 && n < 2 * DIV) begin
      if (tx !== 1'b1) stop_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    a1 = cyc;
    stb = 1'b0;
    check({tag, "_ack_spacing"}, 32'(a1 - a0), 32'(NB * DIV + 1));
    check({tag, "_stop_high"}, 32'(stop_ok), 32'd1);
    rx_frame(f2);
    settle();
  endtask

  initial begin
    logic [10:0] f, g;
    logic [7:0]  r1, r2;
    logic        idle_ok;

    rst = 1'b1;
    stb = 1'b0;
    dat = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_ack", 32'(ack), 32'd0);
    rst = 1'b0;
    idle_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (ack !== 1'b0 || tx !== 1'b1) idle_ok = 1'b0;
    end
    check("idle_no_ack", 32'(idle_ok), 32'd1);

    offer(8'hA5, "a5");
    rx_frame(f);
`ifdef UART_TRANSMIT_PARITY_EN
    check("a5_frame", 32'(f), 32'h54A);
`else
    check("a5_frame", 32'(f), 32'h34A);
`endif
    settle();

`ifndef UART_TRANSMIT_PARITY_EN
    r1 = 8'($urandom_range(0, 255));
    r2 = 8'($urandom_range(0, 255));
    b2b(r1, r2, "rand", f, g);
    check("rand_byte1", 32'(f), 32'(frame_of(r1)));
    check("rand_byte2", 32'(g), 32'(frame_of(r2)));
`endif

    b2b(8'h00, 8'hFF, "b2b", f, g);
    check("b2b_00_frame", 32'(f), 32'(frame_of(8'h00)));
    check("b2b_ff_frame", 32'(g), 32'(frame_of(8'hFF)));

    offer(8'h3C, "x3c");
    repeat (2 * DIV + DIV / 2 - 2) @(negedge clk);
    check("x3c_bit1_low", 32'(tx), 32'd0);
    #2;
    rst = 1'b1;
    stb = 1'b1;
    dat = 8'h81;
    #1;
    check("async_rst_tx", 32'(tx), 32'd1);
    check("async_rst_ack", 32'(ack), 32'd0);
    repeat (3) @(negedge clk);
    check("rst_blocks_stb", 32'(ack), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("x81_ack_after_rst", 32'(ack), 32'd1);
    stb = 1'b0;
    dat = 8'h00;
    rx_frame(f);
    check("x81_frame", 32'(f), 32'(frame_of(8'h81)));
    settle();

`ifdef UART_TRANSMIT_PARITY_EN
    b2b(8'h07, 8'h03, "par", f, g);
    check("par_07_frame", 32'(f), 32'h60E);
    check("par_07_bit", 32'(f[9]), 32'd1);
    check("par_03_frame", 32'(g), 32'h406);
    check("par_03_bit", 32'(g[9]), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
